// File: rtl/multi_tick_gen.sv
// multi_tick_gen: multi-channel programmable tick and square-wave time base
// Ports: clk_2MHz system clock; reset async active-high;
//   enable global run; ch_en per-channel run; sync_clr clears counters and sq;
//   load/load_ch/load_div write one channel's divisor (restarting its count);
//   tick one-cycle strobe per channel; sq toggles on every tick.
// Optional: define MULTI_TICK_GEN_CASCADE_EN so channel i>0 counts ticks of
//   channel i-1 instead of clock edges.
module multi_tick_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 21,
  parameter int CH_W = 2,
  parameter int DEFAULT_DIV = 1000000
) (
  input  logic              clk_2MHz,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
`ifdef MULTI_TICK_GEN_CASCADE_EN
  logic [NUM_CH-1:0] fire;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div, cnt;
    logic t, s, sel, act, term, adv;
    // out-of-range load_ch matches no channel, so such loads are ignored
    assign sel = load && load_ch == CH_W'(i);
`ifdef MULTI_TICK_GEN_CASCADE_EN
    // successors step on the same edge their predecessor issues a tick
    assign fire[i] = act && term && !sel && !sync_clr;
    if (i == 0) begin : g_head
      assign adv = 1'b1;
    end else begin : g_tail
      assign adv = fire[i-1];
    end
`else
    assign adv = 1'b1;
`endif
    assign act = enable && ch_en[i] && div != '0 && adv;
    assign term = cnt == div - DIV_W'(1);
    always_ff @(posedge clk_2MHz or posedge reset)
      if (reset) begin
        div <= DIV_W'(DEFAULT_DIV);
        cnt <= '0;
        t <= 1'b0;
        s <= 1'b0;
      end else begin
        if (sel) div <= load_div;
        if (sync_clr) begin
          cnt <= '0;
          t <= 1'b0;
          s <= 1'b0;
        end else if (sel) begin
          cnt <= '0;
          t <= 1'b0;
        end else if (act && term) begin
          cnt <= '0;
          t <= 1'b1;
          s <= ~s;
        end else begin
          cnt <= act ? cnt + DIV_W'(1) : cnt;
          t <= 1'b0;
        end
      end
    assign tick[i] = t;
    assign sq[i] = s;
  end
endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed table-driven bench for multi_tick_gen
module tb_multi_tick_gen;
  logic clk_2MHz = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [3:0] ch_en = '0;
  logic sync_clr = 1'b0;
  logic load = 1'b0;
  logic [2:0] load_ch = '0;
  logic [20:0] load_div = '0;
  logic [3:0] tick, sq;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic en;
    logic [3:0] ce;
    logic clr;
    logic ld;
    logic [2:0] lc;
    logic [20:0] dv;
    logic [3:0] t;
    logic [3:0] s;
  } vec_t;
  vec_t v[$];
  multi_tick_gen #(.NUM_CH(4), .DIV_W(21), .CH_W(3), .DEFAULT_DIV(5)) dut (
    .clk_2MHz(clk_2MHz),
    .reset(reset),
    .enable(enable),
    .ch_en(ch_en),
    .sync_clr(sync_clr),
    .load(load),
    .load_ch(load_ch),
    .load_div(load_div),
    .tick(tick),
    .sq(sq)
  );
  always #5 clk_2MHz = ~clk_2MHz;
  function automatic vec_t mk(logic en, logic [3:0] ce, logic clr, logic ld, logic [2:0] lc,
                              int dv, logic [3:0] t, logic [3:0] s);
    mk = '{en, ce, clr, ld, lc, 21'(dv), t, s};
  endfunction
  task automatic check(string name, int idx, logic [3:0] et, logic [3:0] es);
    n_checks++;
    if (tick !== et || sq !== es) begin
      n_fail++;
      $display("FAIL %s[%0d]: tick=%b sq=%b, expected tick=%b sq=%b", name, idx, tick, sq, et, es);
    end
  endtask
  task automatic step();
    @(posedge clk_2MHz);
    #1;
  endtask
  initial begin
    v.push_back(mk(1, 4'b0010, 0, 1, 1, 4, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 1, 5, 7, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 1, 1, 3, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 1, 1, 3, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0001, 4'b0001));
    v.push_back(mk(1, 4'b0011, 1, 1, 1, 2, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0010, 4'b0010));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0010, 4'b0000));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0001, 4'b0001));
    v.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0001));
    v.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0010, 4'b0011));
    v.push_back(mk(1, 4'b0011, 0, 1, 0, 0, 4'b0000, 4'b0011));
    step();
    check("reset", 0, 4'b0000, 4'b0000);
    reset = 1'b0;
    enable = 1'b1;
    ch_en = 4'b0001;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("default_div", i, (i % 5 == 0) ? 4'b0001 : 4'b0000, ((i / 5) % 2 == 1) ? 4'b0001 : 4'b0000);
    end
    reset = 1'b1;
    #1;
    check("async_reset", 0, 4'b0000, 4'b0000);
    step();
    reset = 1'b0;
    foreach (v[i]) begin
      enable = v[i].en;
      ch_en = v[i].ce;
      sync_clr = v[i].clr;
      load = v[i].ld;
      load_ch = v[i].lc;
      load_div = v[i].dv;
      step();
      check("vec", i, v[i].t, v[i].s);
    end
    load = 1'b0;
    ch_en = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      step();
      check("div0_halt", i, 4'b0000, 4'b0011);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parametrised multi-channel tick generator. Each channel divides `clk_2MHz` by a run-time programmable divisor. Each channel produces a one-cycle `tick` strobe and a 50%-style `sq` square wave. The block replaces the fixed single 1 Hz divider as the common time base for display refresh, debounce, blink and seconds counting. Per-channel enable/pause, synchronous clear and reprogramming are supported without global reset.

## Interface
- `NUM_CH`, 4, number of independent channels (1..8)
- `DIV_W`, 21, divisor/counter width in bits
- `CH_W`, 2, width of channel index; must satisfy 2^CH_W >= NUM_CH
- `DEFAULT_DIV`, 1000000, divisor loaded into every channel at reset (1 Hz `sq` at 2 MHz)

- `clk_2MHz`  in  1  system clock, 2 MHz
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  global run; 0 pauses all channels
- `ch_en`  in  NUM_CH  per-channel run; 0 pauses that channel
- `sync_clr`  in  1  synchronous clear of all counters and `sq`
- `load`  in  1  write strobe for divisor register
- `load_ch`  in  CH_W  channel index for `load`
- `load_div`  in  DIV_W  new divisor value
- `tick`  out  NUM_CH  one-cycle strobe per channel, registered
- `sq`  out  NUM_CH  square wave per channel; toggles on each tick, registered

## Operation
- Per channel i: registers `div[i]` (DIV_W), `cnt[i]` (DIV_W), `tick[i]`, `sq[i]`.
- Reset values: `cnt` = 0, `div` = DEFAULT_DIV, `tick` = 0, `sq` = 0.
- A channel is active when `enable & ch_en[i]` and `div[i]` != 0.
- Active channel, each edge:
  - if `cnt[i] == div[i]-1`: `cnt[i]` <= 0, `tick[i]` <= 1, `sq[i]` <= ~`sq[i]`;
  - else: `cnt[i]` <= `cnt[i]`+1, `tick[i]` <= 0.
- The tick period is `div[i]` cycles. The `sq` period is 2·`div[i]` cycles.
- `div[i]` = 1: `tick` is high every cycle and `sq` toggles every cycle.
- `div[i]` = 0: the channel is halted. `cnt` holds, `tick` = 0, `sq` holds.
- Inactive channel: `cnt` and `sq` hold (pause, not clear), `tick` = 0.
- `load` with `load_ch` < NUM_CH:
  - `div[load_ch]` <= `load_div`, `cnt[load_ch]` <= 0, `tick[load_ch]` <= 0;
  - `sq` is unchanged;
  - takes effect whether or not the channel is active.
- `load` with `load_ch` >= NUM_CH: ignored.
- Load coinciding with terminal count on the same channel: load wins; no tick, no `sq` toggle.
- `sync_clr`: all `cnt` <= 0, `tick` <= 0, `sq` <= 0; `div` is unchanged.
- `sync_clr` has priority over `load` and counting. A simultaneous `load` still writes `div`.
- Counter arithmetic is unsigned DIV_W bits. The counter never exceeds `div[i]-1` while active, so it cannot wrap.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- From reset release (or `load`/`sync_clr`) with the channel active, the first `tick` asserts on rising edge `div` counted from the first active edge. It is high for exactly one cycle.
- Pausing for k cycles delays every subsequent tick by exactly k cycles.
- `load`/`sync_clr` are sampled on the rising edge; the effect is visible in the same edge's register update.
- Reset mid-count: all state returns to reset values immediately (asynchronously).

## Configuration
- `MULTI_TICK_GEN_CASCADE_EN` defined:
  - channel i>0 advances its counter only on edges where `tick[i-1]` is 1, instead of every clock;
  - channel 0 is unchanged;
  - a paused or halted predecessor stalls all successors;
  - `tick[i]` remains one cycle wide.
- Undefined: every channel counts `clk_2MHz` edges independently.

## Test plan
- Reset defaults: reset pulse, `enable`=1, `ch_en`=4'b0001 → `tick[0]` first high on edge 1000000, `sq[0]` rises there and falls at edge 2000000; other channels' `tick` = 0 and `sq` = 0 throughout.
- Reprogram: load ch1 `div`=4 with `ch_en`=4'b0010 → `tick[1]` high on edges 4, 8, 12…; `sq[1]` period is 8 cycles.
- Pause: ch1 `div`=4, drop `ch_en[1]` for 3 cycles after edge 2 → next tick at edge 7 instead of 4; `sq` holds during the pause.
- Corner divisors: `div`=1 → `tick` constant high and `sq` toggles each edge; `div`=0 → no tick and `cnt` frozen for 100 cycles; `load_ch`=5 with NUM_CH=4 → no state change.
- Collisions: `load` on the terminal-count edge → no tick and the count restarts from 0; `sync_clr` together with `load` → all `sq` = 0 and the new `div` is retained.
- Cascade (macro defined): ch0 `div`=3, ch1 `div`=2 → `tick[1]` on edges 6, 12, 18; undefined → `tick[1]` on edges 2, 4, 6.
